// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter for the single regfile write port.
// NUM_REQ writeback/commit lanes compete for one write per cycle. The winner
// is captured in one output register that drives RegWrite/WriteRegister/
// WriteData. That register also lets read-side bypass logic see the in-flight
// write.
// Optional feature macro: REGFILE_WR_ARB_STATS_EN adds per-requester 16-bit
// saturating grant counters (grant_cnt_o) and a synchronous clear (stats_clr_i).
//
// Handshake: a requester raises req_valid_i[i] and keeps addr/data stable.
// The arbiter answers with a one-hot req_ready_o in the same cycle. A transfer
// happens on the rising edge where valid[i] & ready[i] are both high. Valid
// may drop without ready, for example on a flush. Ready never depends on a
// requester lowering valid.
module regfile_wr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      wr_en_o,
  output logic [ADDR_W-1:0]         wr_addr_o,
  output logic [DATA_W-1:0]         wr_data_o,
  output logic [2:0]                rr_ptr_o
`ifdef REGFILE_WR_ARB_STATS_EN
  ,
  input  logic                      stats_clr_i,
  output logic [NUM_REQ*16-1:0]     grant_cnt_o
`endif
);

  // Round-robin priority pointer: the index searched first this cycle.
  logic [2:0]        r_rr_ptr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_grant_any;
  logic [2:0]        w_grant_idx;
  logic [3:0]        w_cand;
  logic [3:0]        w_ptr_sum;
  logic [2:0]        w_ptr_nxt;
  logic [NUM_REQ-1:0] w_ready;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  // Search for the first valid requester from r_rr_ptr upward, wrapping to 0.
  // Hold or reset suppresses every grant.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = 3'd0;
    w_cand      = 4'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_cand = {1'b0, r_rr_ptr} + 4'(j);
      if (w_cand >= 4'(NUM_REQ)) begin
        w_cand = w_cand - 4'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_grant_any && (w_cand == 4'(i)) && req_valid_i[i]) begin
          w_grant_any = 1'b1;
          w_grant_idx = 3'(i);
        end
      end
    end
    if (hold_i || reset) begin
      w_grant_any = 1'b0;
    end
  end

  // Decode the grant to one-hot and mux the winner's address/data.
  always_comb begin
    w_ready    = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == 3'(i)) begin
        w_ready[i] = w_grant_any;
        w_sel_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // After a grant, the pointer moves to the slot after the winner (mod NUM_REQ).
  always_comb begin
    w_ptr_sum = {1'b0, w_grant_idx} + 4'd1;
    if (w_ptr_sum >= 4'(NUM_REQ)) begin
      w_ptr_sum = 4'd0;
    end
    w_ptr_nxt = w_ptr_sum[2:0];
  end

  // Update the pointer only when a grant is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= 3'd0;
    end else if (w_grant_any) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  // Output stage. Capture the granted write. A zero-register target is
  // accepted but never raises RegWrite. With no grant, address and data hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_grant_any) begin
      r_wr_en   <= (w_sel_addr != ADDR_W'(ZERO_REG));
      r_wr_addr <= w_sel_addr;
      r_wr_data <= w_sel_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign req_ready_o = w_ready;
  assign wr_en_o     = r_wr_en;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign rr_ptr_o    = r_rr_ptr;

`ifdef REGFILE_WR_ARB_STATS_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  // Per-requester saturating grant counters. Clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_grant_cnt[i] <= 16'd0;
      end
    end else if (stats_clr_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_grant_cnt[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_ready[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt_o[g*16 +: 16] = r_grant_cnt[g];
  end
`else
  // Without statistics there are no counters. The grant path is unchanged.
`endif

endmodule
